// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and data
// load/store requesters, tracking the fixed memory latency for the owning side.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  logic [0:0]       state;
  logic [1:0]       owner;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;

  logic done;
  logic issue;
  logic grant_d;
  logic grant_i;

  // Completion cycle doubles as an issue point, so accesses pipeline at MEM_LAT spacing.
  always_comb begin
    done    = (state == S_WAIT) && (lat_cnt == '0);
    issue   = (state == S_IDLE) || done;
    grant_d = issue && d_req && (!if_req || (starve_cnt != STV_MAX));
    grant_i = issue && if_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= OWN_NONE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else if (issue) begin
      if (grant_d || grant_i) begin
        state   <= S_WAIT;
        owner   <= grant_d ? OWN_DATA : OWN_FETCH;
        lat_cnt <= LAT_LOAD;
      end else begin
        state   <= S_IDLE;
        owner   <= OWN_NONE;
        lat_cnt <= '0;
      end
      // Count only data wins that actually made fetch wait.
      if (grant_d && if_req) begin
        if (starve_cnt != STV_MAX) starve_cnt <= starve_cnt + STV_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end else begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Every output is held at zero while reset is asserted.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    if (reset) begin
      if_gnt    = grant_i;
      d_gnt     = grant_d;
      mem_en    = grant_i || grant_d;
      mem_we    = grant_d && d_we;
      if (grant_d)      mem_addr = d_addr;
      else if (grant_i) mem_addr = if_addr;
      if (grant_d && d_we) mem_wdata = d_wdata;
      if_rvalid = done && (owner == OWN_FETCH);
      d_rvalid  = done && (owner == OWN_DATA);
      if (done && (owner == OWN_FETCH)) if_rdata = mem_rdata;
      if (done && (owner == OWN_DATA))  d_rdata  = mem_rdata;
      busy      = (state == S_WAIT);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance against a small
// memory model, plus a MEM_LAT=1 instance for back-to-back fetch.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;

  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req1, d_req1, d_we1;
  logic [31:0] if_addr1, d_addr1, d_wdata1;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1;
  logic [31:0] if_rdata1, d_rdata1;
  logic        mem_en1, mem_we1, busy1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  int n_chk;
  int n_err;

  localparam logic [31:0] A_TEXT  = 32'h0040_0000;
  localparam logic [31:0] A_DATA  = 32'h1001_0000;
  localparam logic [31:0] A_STORE = 32'h1001_0004;
  localparam logic [31:0] K1      = 32'hA5A5_0000;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle read memory with preloaded program/data words.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (!reset) begin
      mem[A_TEXT] = 32'h8C09_0004;
      mem[A_DATA] = 32'h0000_002A;
    end
    rd_p0 <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    rd_p1 <= rd_p0;
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = rd_p1;

  // One-cycle memory whose contents are a fixed function of the address.
  logic [31:0] rd1_p0;
  always @(posedge clk) rd1_p0 <= mem_addr1 ^ K1;
  assign mem_rdata1 = rd1_p0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    if_req  = 1'b0; if_addr  = '0;
    d_req   = 1'b0; d_we     = 1'b0; d_addr  = '0; d_wdata  = '0;
    if_req1 = 1'b0; if_addr1 = '0;
    d_req1  = 1'b0; d_we1    = 1'b0; d_addr1 = '0; d_wdata1 = '0;
    repeat (2) @(negedge clk);
  endtask

  logic [19:0] d_pat;
  logic [19:0] i_pat;

  initial begin
    n_chk = 0;
    n_err = 0;
    d_pat = 20'h15455;
    i_pat = 20'h40100;

    // Outputs forced low while reset is held, even with both requests up.
    do_reset();
    if_req = 1'b1; if_addr = A_TEXT; d_req = 1'b1; d_we = 1'b1;
    d_addr = A_STORE; d_wdata = 32'hFFFF_FFFF;
    #1;
    check_eq("rst if_gnt", 32'(if_gnt), 32'd0);
    check_eq("rst d_gnt", 32'(d_gnt), 32'd0);
    check_eq("rst mem_en", 32'(mem_en), 32'd0);
    check_eq("rst mem_we", 32'(mem_we), 32'd0);
    check_eq("rst mem_addr", mem_addr, 32'd0);
    check_eq("rst mem_wdata", mem_wdata, 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);

    // Fetch alone.
    do_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = A_TEXT;
    #1;
    check_eq("f c0 if_gnt", 32'(if_gnt), 32'd1);
    check_eq("f c0 mem_en", 32'(mem_en), 32'd1);
    check_eq("f c0 mem_addr", mem_addr, A_TEXT);
    check_eq("f c0 busy", 32'(busy), 32'd0);
    check_eq("f c0 d_gnt", 32'(d_gnt), 32'd0);
    cyc(); if_req = 1'b0; #1;
    check_eq("f c1 busy", 32'(busy), 32'd1);
    check_eq("f c1 mem_en", 32'(mem_en), 32'd0);
    check_eq("f c1 if_rvalid", 32'(if_rvalid), 32'd0);
    cyc(); #1;
    check_eq("f c2 busy", 32'(busy), 32'd1);
    check_eq("f c2 if_rvalid", 32'(if_rvalid), 32'd1);
    check_eq("f c2 if_rdata", if_rdata, 32'h8C09_0004);
    check_eq("f c2 d_rvalid", 32'(d_rvalid), 32'd0);
    cyc(); #1;
    check_eq("f c3 busy", 32'(busy), 32'd0);
    check_eq("f c3 if_rvalid", 32'(if_rvalid), 32'd0);

    // Simultaneous fetch and load: data first.
    do_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = A_TEXT;
    d_req = 1'b1; d_we = 1'b0; d_addr = A_DATA;
    #1;
    check_eq("s c0 d_gnt", 32'(d_gnt), 32'd1);
    check_eq("s c0 if_gnt", 32'(if_gnt), 32'd0);
    check_eq("s c0 mem_addr", mem_addr, A_DATA);
    cyc(); d_req = 1'b0; #1;
    check_eq("s c1 if_gnt", 32'(if_gnt), 32'd0);
    cyc(); #1;
    check_eq("s c2 d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("s c2 d_rdata", d_rdata, 32'h0000_002A);
    check_eq("s c2 if_gnt", 32'(if_gnt), 32'd1);
    check_eq("s c2 mem_addr", mem_addr, A_TEXT);
    check_eq("s c2 if_rvalid", 32'(if_rvalid), 32'd0);
    cyc(); if_req = 1'b0; #1;
    check_eq("s c3 if_rvalid", 32'(if_rvalid), 32'd0);
    cyc(); #1;
    check_eq("s c4 if_rvalid", 32'(if_rvalid), 32'd1);
    check_eq("s c4 if_rdata", if_rdata, 32'h8C09_0004);
    check_eq("s c4 d_rvalid", 32'(d_rvalid), 32'd0);

    // Store then load back.
    do_reset();
    reset = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = A_STORE; d_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("st c0 mem_en", 32'(mem_en), 32'd1);
    check_eq("st c0 mem_we", 32'(mem_we), 32'd1);
    check_eq("st c0 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_eq("st c0 mem_addr", mem_addr, A_STORE);
    cyc(); d_req = 1'b0; d_we = 1'b0; #1;
    check_eq("st c1 mem_we", 32'(mem_we), 32'd0);
    cyc(); #1;
    check_eq("st c2 d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("st c2 mem_we", 32'(mem_we), 32'd0);
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = A_STORE; #1;
    check_eq("st c3 d_gnt", 32'(d_gnt), 32'd1);
    check_eq("st c3 mem_we", 32'(mem_we), 32'd0);
    cyc(); d_req = 1'b0; #1;
    cyc(); #1;
    check_eq("st c5 d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("st c5 d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Starvation guard with both requests held.
    do_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = A_TEXT;
    d_req = 1'b1; d_we = 1'b0; d_addr = A_DATA;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) cyc();
      #1;
      check_eq($sformatf("stv c%0d d_gnt", c), 32'(d_gnt), 32'(d_pat[c]));
      check_eq($sformatf("stv c%0d if_gnt", c), 32'(if_gnt), 32'(i_pat[c]));
      if (c == 10) check_eq("stv c10 if_rvalid", 32'(if_rvalid), 32'd1);
    end

    // Reset in the middle of a fetch discards its response.
    do_reset();
    reset = 1'b1; if_req = 1'b1; if_addr = A_TEXT;
    #1;
    check_eq("rm c0 if_gnt", 32'(if_gnt), 32'd1);
    cyc(); reset = 1'b0; #1;
    check_eq("rm c1 busy", 32'(busy), 32'd0);
    check_eq("rm c1 if_gnt", 32'(if_gnt), 32'd0);
    cyc(); #1;
    check_eq("rm c2 if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rm c2 mem_en", 32'(mem_en), 32'd0);
    cyc(); reset = 1'b1; #1;
    check_eq("rm c3 if_gnt", 32'(if_gnt), 32'd1);
    check_eq("rm c3 busy", 32'(busy), 32'd0);
    check_eq("rm c3 if_rvalid", 32'(if_rvalid), 32'd0);
    cyc(); if_req = 1'b0; #1;
    check_eq("rm c4 busy", 32'(busy), 32'd1);
    check_eq("rm c4 if_rvalid", 32'(if_rvalid), 32'd0);
    cyc(); #1;
    check_eq("rm c5 if_rvalid", 32'(if_rvalid), 32'd1);
    check_eq("rm c5 if_rdata", if_rdata, 32'h8C09_0004);

    // MEM_LAT=1: back-to-back fetch every cycle.
    do_reset();
    reset = 1'b1; if_req1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) cyc();
      if_addr1 = A_TEXT + 32'(4 * c);
      #1;
      check_eq($sformatf("l1 c%0d if_gnt", c), 32'(if_gnt1), 32'd1);
      check_eq($sformatf("l1 c%0d mem_addr", c), mem_addr1, A_TEXT + 32'(4 * c));
      check_eq($sformatf("l1 c%0d if_rvalid", c), 32'(if_rvalid1), (c == 0) ? 32'd0 : 32'd1);
      if (c != 0)
        check_eq($sformatf("l1 c%0d if_rdata", c), if_rdata1, (A_TEXT + 32'(4 * (c - 1))) ^ K1);
    end
    cyc(); if_req1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the instruction-fetch requester and the data (load/store) requester of the MIPS datapath.
- Issues one access at a time, counts the fixed memory latency and returns read data or write completion to the owning requester.
- Prefers data accesses, with a starvation guard for fetch.
- Sits between the datapath's fetch/memory stages and the memory macro; the controller holds the PC while a fetch is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from issue (mem_en) to valid mem_rdata; legal range >= 1
STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch access issued this cycle
if_rvalid  output  1  fetch data valid this cycle
if_rdata  output  DATA_W  fetch data
d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_gnt  output  1  data access issued this cycle
d_rvalid  output  1  load data valid / store complete this cycle
d_rdata  output  DATA_W  load data
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write; only ever high with mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  access outstanding (WAIT state)

Behaviour:
- Reset (reset==0 at a clock edge):
  - State -> IDLE; latency and starvation counters -> 0; owner -> none.
  - While reset is low, every output is forced to 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata, busy.
- States: IDLE and WAIT.
  - WAIT holds the owner (FETCH/DATA) and a down-counter lat_cnt.
- Issue point: IDLE, or WAIT with lat_cnt==0.
  - Arbitration runs combinationally from the requests.
  - Winner gets gnt=1, mem_en=1, with mem_addr and mem_we/mem_wdata taken from the winner's inputs in the same cycle.
  - Next state is WAIT with lat_cnt=MEM_LAT-1 and owner=winner. With no request, next state is IDLE.
- Arbitration:
  - Only d_req -> data wins. Only if_req -> fetch wins.
  - Both requesting -> data wins, unless starve_cnt==STARVE_MAX, in which case fetch wins.
- starve_cnt, updated at issue points only:
  - Data grant with if_req=1 -> starve_cnt+1, saturating at STARVE_MAX.
  - Fetch grant, or if_req=0 -> 0.
- WAIT:
  - lat_cnt decrements each cycle while non-zero; busy=1 throughout WAIT.
  - In the WAIT cycle with lat_cnt==0 (= issue cycle + MEM_LAT), the owner's rvalid=1 for exactly one cycle.
  - The owner's rdata = mem_rdata, passed through combinationally.
  - For stores, d_rvalid signals completion and d_rdata is don't-care.
- A new issue may occur in that same completion cycle, giving throughput of one access per MEM_LAT cycles.
  - MEM_LAT=1 allows back-to-back issue every cycle.
- Non-owner rvalid is always 0. gnt is never asserted in WAIT with lat_cnt!=0.
- Requests dropped before grant are legal and simply lose arbitration. Requests changed while held and before grant are a requester protocol violation; behaviour is undefined.
- Reset mid-access discards the outstanding response: no rvalid follows for that access.

Test Plan:
- Common settings: MEM_LAT=2, STARVE_MAX=4; cycle 0 = first cycle after reset release.
- Fetch alone: if_req=1, if_addr=0x00400000 at cycle 0; mem[0x00400000]=0x8C090004 -> if_gnt=mem_en=1 at cycle 0, busy cycles 1-2, if_rvalid=1 with if_rdata=0x8C090004 at cycle 2, no d_* activity.
- Simultaneous: if_req and d_req (load, 0x10010000 holding 0x0000002A) both at cycle 0 -> d_gnt at cycle 0; d_rvalid with 0x2A and if_gnt at cycle 2; if_rvalid at cycle 4.
- Store: d_req=1, d_we=1, d_addr=0x10010004, d_wdata=0xDEADBEEF -> mem_en=mem_we=1 for only cycle 0; a later read of 0x10010004 returns 0xDEADBEEF; d_rvalid at cycle 2; mem_we low all other cycles.
- Starvation: if_req and d_req held high continuously -> d_gnt at cycles 0, 2, 4, 6; if_gnt at cycle 8; d_gnt at cycle 10; starve_cnt back to 1 after cycle 10.
- Reset mid-op: fetch issued at cycle 0, reset=0 during cycle 1 edge -> all outputs 0, no if_rvalid at cycle 2; after release with if_req held, fresh if_gnt on first cycle out of reset.
- MEM_LAT=1: only if_req held high -> if_gnt every cycle; if_rvalid every cycle from cycle 1, each returning data for the address issued the previous cycle.
